usb_buffer_arbiter: RTL and testbench
=====================================

// Module: usb_buffer_arbiter
// PURPOSE
//  Arbitrates one single-port 64-byte data buffer among four requesters:
//  - USB RX write, USB TX read, AHB-slave write, AHB-slave read.
//  Holds the FIFO read/write pointers and the occupancy count.
//  Generates the RAM strobes and returns read data to the requester that won.
//  Sits between the AHB-lite slave register block, the USB RX/TX engines and the buffer RAM.
// PARAMETERS
//  DEPTH  64  buffer entries (power of 2)
//  PTR_W  6   pointer width = log2(DEPTH)
//  OCC_W  7   occupancy width = PTR_W+1
// PORTS
//  clk               in   1      system clock
//  rst               in   1      synchronous reset, active-high
//  clear             in   1      sync buffer flush (from AHB slave)
//  rx_wreq           in   1      USB RX write request; level, held until rx_wack
//  rx_wdata          in   8      USB RX write byte
//  rx_wack           out  1      RX write granted this cycle
//  tx_rreq           in   1      USB TX read request; level, held until tx_rack
//  tx_rack           out  1      TX read granted this cycle
//  tx_rdata          out  8      TX read byte; valid when tx_rvalid
//  tx_rvalid         out  1      pulse 1 cycle after tx_rack
//  ahb_wreq          in   1      AHB write request (store_tx_data)
//  ahb_wdata         in   8      AHB write byte
//  ahb_wack          out  1      AHB write granted
//  ahb_rreq          in   1      AHB read request (get_rx_data)
//  ahb_rack          out  1      AHB read granted
//  ahb_rdata         out  8      AHB read byte; valid when ahb_rvalid
//  ahb_rvalid        out  1      pulse 1 cycle after ahb_rack
//  mem_wen           out  1      RAM write enable
//  mem_addr          out  PTR_W  RAM address
//  mem_wdata         out  8      RAM write data
//  mem_rdata         in   8      RAM read data; 1-cycle latency after address
//  buffer_occupancy  out  OCC_W  bytes stored, 0..DEPTH
//  err_overflow      out  1      sticky: write attempted while full
//  err_underflow     out  1      sticky: read attempted while empty
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//  - wr_ptr=rd_ptr=0, occupancy=0, both err flags 0, both toggle bits 0.
//  - All acks, rvalids and mem_wen are 0. ahb_rdata/tx_rdata = 8'h00.
//  - A pending read return is dropped.
//  Grant rules
//  - At most one grant per cycle; ack is combinational in the grant cycle.
//  - Requester deasserts its request the cycle after its ack.
//  - USB group {rx_wreq, tx_rreq} has strict priority over AHB group {ahb_wreq, ahb_rreq}.
//  - Inside each group: round-robin toggle bit.
//    - usb_last / ahb_last record which member won last.
//    - On a tie, the other member wins.
//    - Toggle bit updates only when that group is granted.
//  - While clear=1: no grants. Pointers/occupancy -> 0 and err flags -> 0 at the next edge.
//  Write grant
//  - Not full: mem_wen=1, mem_addr=wr_ptr. wr_ptr+1 (wraps DEPTH-1 -> 0). occupancy+1.
//  - Full (occupancy==DEPTH): still acked; mem_wen=0, byte dropped, err_overflow<=1.
//  Read grant
//  - Not empty: mem_addr=rd_ptr. rd_ptr+1 (wraps). occupancy-1.
//  - Next cycle: winner's rvalid=1 and rdata=mem_rdata (registered).
//  - Empty: still acked, no pointer change, err_underflow<=1, next cycle rvalid=1 with rdata=8'h00.
//  Pipelining and counters
//  - A new grant may issue in the same cycle as a read return.
//  - A read return already in flight when clear asserts is still delivered.
//  - Only one access per cycle, so occupancy changes by at most +/-1.
//  - Pointer compare is modulo DEPTH; full/empty are decided solely from occupancy.
//  - mem_addr = 0 and mem_wdata = 0 when there is no grant.
// TESTING
//  1. Reset, then 3 rx_wreq bytes 11,22,33 followed by 3 tx_rreq
//     -> occupancy 3 then 0; tx_rdata 11,22,33, each 1 cycle after its ack.
//  2. rx_wreq, tx_rreq, ahb_wreq, ahb_rreq all held high for 4 cycles
//     -> grants RX,TX,RX,TX; AHB never acked until both USB requests drop.
//  3. 64 ahb_wreq, then a 65th
//     -> occupancy 64; 65th acked with mem_wen=0, err_overflow=1; ptr wrap 63->0 checked.
//  4. Empty buffer, ahb_rreq
//     -> ahb_rack, next cycle ahb_rvalid=1, ahb_rdata=00, err_underflow=1, occupancy stays 0.
//  5. Occupancy 10 plus an in-flight read, then clear pulse with rx_wreq held
//     -> no grant that cycle; rvalid still fires; occupancy 0, errs 0; rx_wack the cycle after.
//  6. rst asserted with occupancy 5 during a read return
//     -> next cycle all outputs at reset values, rvalid=0.

Source files
------------

// File: rtl/usb_buffer_arbiter_if.sv
// Handshake bundle between the buffer arbiter, its four requesters and the buffer RAM.
// The master side is the environment; the slave side is the arbiter.
interface usb_buffer_arbiter_if #(
    parameter int unsigned PTR_W = 6,
    parameter int unsigned OCC_W = 7
);
    logic             clear;
    logic             rx_wreq;
    logic [7:0]       rx_wdata;
    logic             rx_wack;
    logic             tx_rreq;
    logic             tx_rack;
    logic [7:0]       tx_rdata;
    logic             tx_rvalid;
    logic             ahb_wreq;
    logic [7:0]       ahb_wdata;
    logic             ahb_wack;
    logic             ahb_rreq;
    logic             ahb_rack;
    logic [7:0]       ahb_rdata;
    logic             ahb_rvalid;
    logic             mem_wen;
    logic [PTR_W-1:0] mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output clear, rx_wreq, rx_wdata, tx_rreq, ahb_wreq, ahb_wdata, ahb_rreq, mem_rdata,
        input  rx_wack, tx_rack, tx_rdata, tx_rvalid, ahb_wack, ahb_rack, ahb_rdata, ahb_rvalid,
        input  mem_wen, mem_addr, mem_wdata, buffer_occupancy, err_overflow, err_underflow
    );

    modport slave (
        input  clear, rx_wreq, rx_wdata, tx_rreq, ahb_wreq, ahb_wdata, ahb_rreq, mem_rdata,
        output rx_wack, tx_rack, tx_rdata, tx_rvalid, ahb_wack, ahb_rack, ahb_rdata, ahb_rvalid,
        output mem_wen, mem_addr, mem_wdata, buffer_occupancy, err_overflow, err_underflow
    );
endinterface

// File: rtl/usb_buffer_arbiter.sv
// Single-port 64-byte FIFO buffer shared by USB RX/TX and the AHB slave.
// USB has strict priority over AHB; each group round-robins between its writer and reader.
module usb_buffer_arbiter #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PTR_W = 6,
    parameter int unsigned OCC_W = 7
) (
    input logic                clk,
    input logic                rst,
    usb_buffer_arbiter_if.slave bus
);
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             err_ov_q, err_un_q;
    // Toggle bits: 1 means the write member of the group won last.
    logic             usb_last_q, ahb_last_q;
    logic             tx_rvalid_q, ahb_rvalid_q, ret_zero_q;

    logic g_rx, g_tx, g_aw, g_ar;
    logic wr_grant, rd_grant, full, empty;

    always_comb begin
        g_rx = 1'b0;
        g_tx = 1'b0;
        g_aw = 1'b0;
        g_ar = 1'b0;
        if (!bus.clear) begin
            if (bus.rx_wreq && bus.tx_rreq) begin
                g_rx = ~usb_last_q;
                g_tx = usb_last_q;
            end else if (bus.rx_wreq || bus.tx_rreq) begin
                g_rx = bus.rx_wreq;
                g_tx = bus.tx_rreq;
            end else if (bus.ahb_wreq && bus.ahb_rreq) begin
                g_aw = ~ahb_last_q;
                g_ar = ahb_last_q;
            end else begin
                g_aw = bus.ahb_wreq;
                g_ar = bus.ahb_rreq;
            end
        end
    end

    assign wr_grant = g_rx | g_aw;
    assign rd_grant = g_tx | g_ar;
    assign full     = (occ_q == OCC_W'(DEPTH));
    assign empty    = (occ_q == '0);

    assign bus.rx_wack  = g_rx;
    assign bus.tx_rack  = g_tx;
    assign bus.ahb_wack = g_aw;
    assign bus.ahb_rack = g_ar;

    assign bus.mem_wen   = wr_grant & ~full;
    assign bus.mem_addr  = wr_grant ? wr_ptr_q : (rd_grant ? rd_ptr_q : '0);
    assign bus.mem_wdata = g_rx ? bus.rx_wdata : (g_aw ? bus.ahb_wdata : 8'h00);

    // RAM output is already registered, so the return is steered straight through.
    assign bus.tx_rdata   = (tx_rvalid_q && !ret_zero_q) ? bus.mem_rdata : 8'h00;
    assign bus.ahb_rdata  = (ahb_rvalid_q && !ret_zero_q) ? bus.mem_rdata : 8'h00;
    assign bus.tx_rvalid  = tx_rvalid_q;
    assign bus.ahb_rvalid = ahb_rvalid_q;

    assign bus.buffer_occupancy = occ_q;
    assign bus.err_overflow     = err_ov_q;
    assign bus.err_underflow    = err_un_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            err_ov_q     <= 1'b0;
            err_un_q     <= 1'b0;
            usb_last_q   <= 1'b0;
            ahb_last_q   <= 1'b0;
            tx_rvalid_q  <= 1'b0;
            ahb_rvalid_q <= 1'b0;
            ret_zero_q   <= 1'b0;
        end else begin
            tx_rvalid_q  <= g_tx;
            ahb_rvalid_q <= g_ar;
            ret_zero_q   <= empty;
            if (bus.clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                err_ov_q <= 1'b0;
                err_un_q <= 1'b0;
            end else if (wr_grant) begin
                if (full) begin
                    err_ov_q <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    occ_q    <= occ_q + OCC_W'(1);
                end
            end else if (rd_grant) begin
                if (empty) begin
                    err_un_q <= 1'b1;
                end else begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    occ_q    <= occ_q - OCC_W'(1);
                end
            end
            if (g_rx || g_tx) usb_last_q <= g_rx;
            if (g_aw || g_ar) ahb_last_q <= g_aw;
        end
    end
endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Bench for usb_buffer_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_usb_buffer_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_buffer_arbiter_if #(.PTR_W(6), .OCC_W(7)) bus ();

    usb_buffer_arbiter #(.DEPTH(64), .PTR_W(6), .OCC_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Buffer RAM with one cycle of read latency.
    logic [7:0] ram [64];
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: buffer contents as a queue, pointers as indices modulo 64.
    logic [7:0] m_q[$];
    int         m_wr, m_rd;
    bit         m_ov, m_un, m_usb_w, m_ahb_w, m_pend_tx, m_pend_ahb;
    logic [7:0] m_pend_d;
    bit         g_rx, g_tx, g_aw, g_ar, e_wr, e_rd, e_wen;
    logic [7:0] e_wd;
    logic [5:0] e_addr;

    always @(negedge clk) begin
        g_rx = 1'b0; g_tx = 1'b0; g_aw = 1'b0; g_ar = 1'b0;
        if (!bus.clear) begin
            if (bus.rx_wreq && bus.tx_rreq) begin
                g_rx = !m_usb_w; g_tx = m_usb_w;
            end else if (bus.rx_wreq || bus.tx_rreq) begin
                g_rx = bus.rx_wreq; g_tx = bus.tx_rreq;
            end else if (bus.ahb_wreq && bus.ahb_rreq) begin
                g_aw = !m_ahb_w; g_ar = m_ahb_w;
            end else begin
                g_aw = bus.ahb_wreq; g_ar = bus.ahb_rreq;
            end
        end
        e_wr   = g_rx || g_aw;
        e_rd   = g_tx || g_ar;
        e_wen  = e_wr && (m_q.size() < 64);
        e_wd   = g_rx ? bus.rx_wdata : (g_aw ? bus.ahb_wdata : 8'h00);
        e_addr = e_wr ? 6'(m_wr) : (e_rd ? 6'(m_rd) : 6'd0);
        if (chk_en) begin
            chk("occupancy", 32'(bus.buffer_occupancy), m_q.size());
            chk("err_overflow", 32'(bus.err_overflow), 32'(m_ov));
            chk("err_underflow", 32'(bus.err_underflow), 32'(m_un));
            chk("tx_rvalid", 32'(bus.tx_rvalid), 32'(m_pend_tx));
            chk("ahb_rvalid", 32'(bus.ahb_rvalid), 32'(m_pend_ahb));
            if (m_pend_tx) chk("tx_rdata", 32'(bus.tx_rdata), 32'(m_pend_d));
            if (m_pend_ahb) chk("ahb_rdata", 32'(bus.ahb_rdata), 32'(m_pend_d));
            if (!rst) begin
                chk("rx_wack", 32'(bus.rx_wack), 32'(g_rx));
                chk("tx_rack", 32'(bus.tx_rack), 32'(g_tx));
                chk("ahb_wack", 32'(bus.ahb_wack), 32'(g_aw));
                chk("ahb_rack", 32'(bus.ahb_rack), 32'(g_ar));
                chk("mem_wen", 32'(bus.mem_wen), 32'(e_wen));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
                if (e_wen || !(e_wr || e_rd)) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
            end
        end
        if (rst) begin
            m_q.delete();
            m_wr = 0; m_rd = 0; m_ov = 1'b0; m_un = 1'b0;
            m_usb_w = 1'b0; m_ahb_w = 1'b0;
            m_pend_tx = 1'b0; m_pend_ahb = 1'b0; m_pend_d = 8'h00;
        end else begin
            m_pend_tx  = g_tx;
            m_pend_ahb = g_ar;
            if (bus.clear) begin
                m_q.delete();
                m_wr = 0; m_rd = 0; m_ov = 1'b0; m_un = 1'b0;
            end else if (e_wr) begin
                if (m_q.size() == 64) m_ov = 1'b1;
                else begin
                    m_q.push_back(e_wd);
                    m_wr = (m_wr + 1) % 64;
                end
            end else if (e_rd) begin
                if (m_q.size() == 0) begin
                    m_un = 1'b1;
                    m_pend_d = 8'h00;
                end else begin
                    m_pend_d = m_q.pop_front();
                    m_rd = (m_rd + 1) % 64;
                end
            end
            if (g_rx || g_tx) m_usb_w = g_rx;
            if (g_aw || g_ar) m_ahb_w = g_aw;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input bit v, input logic [7:0] d);
        case (who)
            0: begin bus.rx_wreq = v; bus.rx_wdata = d; end
            1: bus.tx_rreq = v;
            2: begin bus.ahb_wreq = v; bus.ahb_wdata = d; end
            default: bus.ahb_rreq = v;
        endcase
    endtask

    function automatic logic get_ack(input int who);
        case (who)
            0: return bus.rx_wack;
            1: return bus.tx_rack;
            2: return bus.ahb_wack;
            default: return bus.ahb_rack;
        endcase
    endfunction

    // One request from asserting to its read return (if any).
    task automatic req_one(input int who, input logic [7:0] d, output logic wen,
                           output logic [5:0] addr, output logic rv, output logic [7:0] rd);
        logic ack;
        int   n;
        step();
        set_req(who, 1'b1, d);
        ack = 1'b0;
        n = 0;
        wen = 1'b0;
        addr = 6'd0;
        while (!ack && n < 20) begin
            @(negedge clk);
            ack = get_ack(who);
            wen = bus.mem_wen;
            addr = bus.mem_addr;
            n++;
        end
        if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
        step();
        set_req(who, 1'b0, 8'h00);
        @(negedge clk);
        rv = (who == 1) ? bus.tx_rvalid : bus.ahb_rvalid;
        rd = (who == 1) ? bus.tx_rdata : bus.ahb_rdata;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.rx_wreq = 1'b0; bus.tx_rreq = 1'b0; bus.ahb_wreq = 1'b0; bus.ahb_rreq = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic wen, rv;
        logic [5:0] addr;
        logic [7:0] rd;
        logic [7:0] wbytes [3];
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        bus.clear = 1'b0;
        bus.rx_wreq = 1'b0; bus.rx_wdata = 8'h00; bus.tx_rreq = 1'b0;
        bus.ahb_wreq = 1'b0; bus.ahb_wdata = 8'h00; bus.ahb_rreq = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_occupancy", 32'(bus.buffer_occupancy), 32'd0);
        chk("reset_errs", 32'({bus.err_overflow, bus.err_underflow}), 32'd0);
        chk("reset_rdata", 32'({bus.tx_rdata, bus.ahb_rdata}), 32'd0);

        // Three RX writes then three TX reads.
        for (int i = 0; i < 3; i++) req_one(0, wbytes[i], wen, addr, rv, rd);
        chk("t1_occupancy3", 32'(bus.buffer_occupancy), 32'd3);
        for (int i = 0; i < 3; i++) begin
            req_one(1, 8'h00, wen, addr, rv, rd);
            chk("t1_rvalid", 32'(rv), 32'd1);
            chk("t1_rdata", 32'(rd), 32'(wbytes[i]));
        end
        chk("t1_occupancy0", 32'(bus.buffer_occupancy), 32'd0);

        // All four requesting: USB alternates, AHB starved.
        step();
        bus.rx_wreq = 1'b1; bus.rx_wdata = 8'h5c; bus.tx_rreq = 1'b1;
        bus.ahb_wreq = 1'b1; bus.ahb_wdata = 8'h77; bus.ahb_rreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_rx_wack", 32'(bus.rx_wack), 32'(i % 2 == 0));
            chk("t2_tx_rack", 32'(bus.tx_rack), 32'(i % 2 == 1));
            chk("t2_ahb_idle", 32'({bus.ahb_wack, bus.ahb_rack}), 32'd0);
            step();
        end
        bus.rx_wreq = 1'b0; bus.tx_rreq = 1'b0;
        @(negedge clk);
        chk("t2_ahb_wack", 32'({bus.ahb_wack, bus.ahb_rack}), 32'b10);
        step();
        @(negedge clk);
        chk("t2_ahb_rack", 32'({bus.ahb_wack, bus.ahb_rack}), 32'b01);
        step();
        bus.ahb_wreq = 1'b0; bus.ahb_rreq = 1'b0;

        // Fill to full, overflow, then check pointer wrap.
        do_reset();
        for (int i = 0; i < 64; i++) req_one(2, 8'(i + 1), wen, addr, rv, rd);
        chk("t3_occupancy64", 32'(bus.buffer_occupancy), 32'd64);
        req_one(2, 8'hab, wen, addr, rv, rd);
        chk("t3_full_wen", 32'(wen), 32'd0);
        chk("t3_overflow", 32'(bus.err_overflow), 32'd1);
        chk("t3_occupancy_full", 32'(bus.buffer_occupancy), 32'd64);
        req_one(3, 8'h00, wen, addr, rv, rd);
        chk("t3_first_byte", 32'(rd), 32'h01);
        req_one(2, 8'hee, wen, addr, rv, rd);
        chk("t3_wrap_wen", 32'(wen), 32'd1);
        chk("t3_wrap_addr", 32'(addr), 32'd0);

        // Empty read.
        do_reset();
        req_one(3, 8'h00, wen, addr, rv, rd);
        chk("t4_rvalid", 32'(rv), 32'd1);
        chk("t4_rdata", 32'(rd), 32'h00);
        chk("t4_underflow", 32'(bus.err_underflow), 32'd1);
        chk("t4_occupancy", 32'(bus.buffer_occupancy), 32'd0);

        // Clear with a read return in flight and RX held.
        do_reset();
        req_one(3, 8'h00, wen, addr, rv, rd);
        for (int i = 0; i < 10; i++) req_one(0, 8'(8'ha0 + i), wen, addr, rv, rd);
        step();
        bus.tx_rreq = 1'b1;
        @(negedge clk);
        chk("t5_tx_rack", 32'(bus.tx_rack), 32'd1);
        step();
        bus.tx_rreq = 1'b0; bus.clear = 1'b1; bus.rx_wreq = 1'b1; bus.rx_wdata = 8'h5a;
        @(negedge clk);
        chk("t5_no_grant", 32'(bus.rx_wack), 32'd0);
        chk("t5_rvalid", 32'(bus.tx_rvalid), 32'd1);
        chk("t5_rdata", 32'(bus.tx_rdata), 32'ha0);
        step();
        bus.clear = 1'b0;
        @(negedge clk);
        chk("t5_occupancy", 32'(bus.buffer_occupancy), 32'd0);
        chk("t5_errs", 32'({bus.err_overflow, bus.err_underflow}), 32'd0);
        chk("t5_rx_wack", 32'(bus.rx_wack), 32'd1);
        step();
        bus.rx_wreq = 1'b0;

        // Reset while a read is being granted drops the return.
        do_reset();
        for (int i = 0; i < 5; i++) req_one(0, 8'(8'h40 + i), wen, addr, rv, rd);
        step();
        bus.tx_rreq = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.tx_rreq = 1'b0;
        @(negedge clk);
        chk("t6_rvalid", 32'({bus.tx_rvalid, bus.ahb_rvalid}), 32'd0);
        chk("t6_rdata", 32'(bus.tx_rdata), 32'h00);
        chk("t6_occupancy", 32'(bus.buffer_occupancy), 32'd0);
        chk("t6_mem", 32'({bus.mem_wen, bus.mem_addr}), 32'd0);

        // Random traffic; phases alternate between write-heavy and read-heavy.
        for (int c = 0; c < 3000; c++) begin
            int pw, pr;
            pw = ((c / 400) % 2 == 0) ? 85 : 15;
            pr = 100 - pw;
            step();
            if (g_rx) bus.rx_wreq = 1'b0;
            else if (!bus.rx_wreq && $urandom_range(99) < pw) begin
                bus.rx_wreq = 1'b1; bus.rx_wdata = 8'($urandom);
            end
            if (g_tx) bus.tx_rreq = 1'b0;
            else if (!bus.tx_rreq && $urandom_range(99) < pr) bus.tx_rreq = 1'b1;
            if (g_aw) bus.ahb_wreq = 1'b0;
            else if (!bus.ahb_wreq && $urandom_range(99) < pw) begin
                bus.ahb_wreq = 1'b1; bus.ahb_wdata = 8'($urandom);
            end
            if (g_ar) bus.ahb_rreq = 1'b0;
            else if (!bus.ahb_rreq && $urandom_range(99) < pr) bus.ahb_rreq = 1'b1;
            bus.clear = ($urandom_range(299) == 0);
            rst = ($urandom_range(999) == 0);
        end
        step();
        rst = 1'b0;
        bus.clear = 1'b0;
        bus.rx_wreq = 1'b0; bus.tx_rreq = 1'b0; bus.ahb_wreq = 1'b0; bus.ahb_rreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
